// File: rtl/cpu_bus1_master_pkg.sv
// cpu_bus1_master_pkg: bus-1 sizes, CPU address split, C1 command codes and master FSM states
package cpu_bus1_master_pkg;
    localparam int ADDR1_BUS_SIZE    = 15;
    localparam int DATA1_BUS_SIZE    = 16;
    localparam int CTR1_BUS_SIZE     = 3;
    localparam int CACHE_TAG_SIZE    = 10;
    localparam int CACHE_SET_SIZE    = 5;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int ADDR_SIZE         = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;

    // WRITE32 and RESPONSE share a code: the master only drives it, the cache only answers with it
    localparam logic [CTR1_BUS_SIZE-1:0]
        C1_NOP             = 3'd0,
        C1_READ8           = 3'd1,
        C1_READ16          = 3'd2,
        C1_READ32          = 3'd3,
        C1_INVALIDATE_LINE = 3'd4,
        C1_WRITE8          = 3'd5,
        C1_WRITE16         = 3'd6,
        C1_WRITE32         = 3'd7,
        C1_RESPONSE        = 3'd7;

    typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT_RESP, RECV2, DONE} state_t;

    function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
        return cmd == C1_WRITE8 || cmd == C1_WRITE16 || cmd == C1_WRITE32;
    endfunction
endpackage

// File: rtl/cpu_bus1_master.sv
// cpu_bus1_master: serialises one CPU request onto bus 1 (C1/A1/D1) and returns a single-cycle completion
// Ports: CLK/RESET (async, active-high); req_valid/req_ready/req_cmd/req_addr/req_wdata request side;
//        resp_valid/resp_err/resp_rdata completion side; A1/D1/C1 shared tristate bus.
module cpu_bus1_master
    import cpu_bus1_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CTR1_BUS_SIZE-1:0]  req_cmd,
    input  logic [ADDR_SIZE-1:0]      req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic                      resp_err,
    output logic [31:0]               resp_rdata,
    inout  logic [ADDR1_BUS_SIZE-1:0] A1,
    inout  logic [DATA1_BUS_SIZE-1:0] D1,
    inout  logic [CTR1_BUS_SIZE-1:0]  C1
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                     state_q, state_d;
    logic [CTR1_BUS_SIZE-1:0]   cmd_q, cmd_d;
    logic [ADDR_SIZE-1:0]       addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic                       oe_q, oe_d;
    logic [ADDR1_BUS_SIZE-1:0]  a1_drv;
    logic [DATA1_BUS_SIZE-1:0]  d1_drv;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                cmd_d   = req_cmd;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = req_cmd == C1_NOP ? DONE : SEND1;
            end
            SEND1: state_d = SEND2;
            SEND2: state_d = WAIT_RESP;
            WAIT_RESP: begin
                cnt_d = cnt_q + 1'b1;
                // a response on the timeout edge wins over the timeout
                if (C1 == C1_RESPONSE) begin
                    rdata_d = cmd_q == C1_READ8 ? {24'b0, D1[7:0]} :
                              (cmd_q == C1_READ16 || cmd_q == C1_READ32) ? {16'b0, D1} : rdata_q;
                    state_d = cmd_q == C1_READ32 ? RECV2 : DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RECV2: begin
                rdata_d = {D1, rdata_q[15:0]};
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        oe_d = state_q == SEND1 || state_q == SEND2;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cmd_q   <= C1_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Output enable moves on the falling edge: it rises mid-SEND1 and drops half a cycle after
    // SEND2, so tick-2 values stay stable across the cache's sampling edge before release.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) oe_q <= 1'b0;
        else       oe_q <= oe_d;
    end

    assign a1_drv = state_q == SEND1 ? addr_q[ADDR_SIZE-1:CACHE_OFFSET_SIZE]
                                     : {{(ADDR1_BUS_SIZE-CACHE_OFFSET_SIZE){1'b0}}, addr_q[CACHE_OFFSET_SIZE-1:0]};
    assign d1_drv = (cmd_q == C1_WRITE32 && state_q != SEND1) ? wdata_q[31:16] : wdata_q[15:0];

    assign A1 = oe_q ? a1_drv : 'z;
    assign C1 = oe_q ? cmd_q : 'z;
    assign D1 = (oe_q && is_write(cmd_q)) ? d1_drv : 'z;

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == DONE;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
endmodule

// File: tb/tb_cpu_bus1_master.sv
// tb_cpu_bus1_master: directed self-checking bench for cpu_bus1_master with a simple bus-1 responder
module tb_cpu_bus1_master;
    import cpu_bus1_master_pkg::*;

    logic        CLK, RESET;
    logic        req_valid, req_ready;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    wire  [14:0] A1;
    wire  [15:0] D1;
    wire  [2:0]  C1;

    logic        tb_a1_oe, tb_d1_oe, tb_c1_oe;
    logic [15:0] tb_d1;
    logic [2:0]  tb_c1;
    int          checks, errors, pulses, p0;

    // The responder parks released lines low, so a line still driven by the master shows up as non-zero/X.
    assign A1 = tb_a1_oe ? 15'h0 : 'z;
    assign D1 = tb_d1_oe ? tb_d1 : 'z;
    assign C1 = tb_c1_oe ? tb_c1 : 'z;

    cpu_bus1_master dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .A1(A1), .D1(D1), .C1(C1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) if (resp_valid) pulses <= pulses + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic park();
        tb_a1_oe = 1'b1; tb_d1_oe = 1'b1; tb_c1_oe = 1'b1; tb_d1 = 16'h0; tb_c1 = C1_NOP;
    endtask

    // Called just after a falling edge while the master is idle; returns 1 ns after the accepting edge.
    task automatic send_req(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata);
        tb_a1_oe = 1'b0; tb_d1_oe = 1'b0; tb_c1_oe = 1'b0;
        req_cmd = cmd; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        park(); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 00000000", resp_rdata); end
        checks++; if ({A1, D1, C1} !== 34'h0) begin errors++; $display("FAIL rst_bus: got %h/%h/%h exp released", A1, D1, C1); end
        @(negedge CLK); RESET = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b exp 1", req_ready); end
    endtask

    task automatic test_read8();
        send_req(C1_READ8, 19'h12345, 32'h0);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL r8_busy: got %b exp 0", req_ready); end
        @(negedge CLK); #1;
        checks++; if (A1 !== 15'h1234) begin errors++; $display("FAIL r8_tick1_a1: got %h exp 1234", A1); end
        checks++; if (C1 !== C1_READ8) begin errors++; $display("FAIL r8_tick1_c1: got %h exp 1", C1); end
        @(negedge CLK); #1;
        checks++; if (A1 !== 15'h0005) begin errors++; $display("FAIL r8_tick2_a1: got %h exp 0005", A1); end
        checks++; if (C1 !== C1_READ8) begin errors++; $display("FAIL r8_tick2_c1: got %h exp 1", C1); end
        @(negedge CLK); park(); #1;
        checks++; if ({A1, D1, C1} !== 34'h0) begin errors++; $display("FAIL r8_release: got %h/%h/%h exp released", A1, D1, C1); end
        repeat (4) @(negedge CLK);
        tb_c1 = C1_RESPONSE; tb_d1 = 16'h00AB;
        @(negedge CLK); tb_c1 = C1_NOP; tb_d1 = 16'h0; #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL r8_resp: got valid %b err %b exp 1 0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h000000AB) begin errors++; $display("FAIL r8_rdata: got %h exp 000000AB", resp_rdata); end
        @(negedge CLK); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL r8_idle: got valid %b ready %b exp 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_read32();
        p0 = pulses;
        send_req(C1_READ32, 19'h0ABC3, 32'h0);
        @(negedge CLK); #1;
        checks++; if (C1 !== C1_READ32) begin errors++; $display("FAIL r32_tick1_c1: got %h exp 3", C1); end
        @(negedge CLK);
        @(negedge CLK); park();
        repeat (2) @(negedge CLK);
        tb_c1 = C1_RESPONSE; tb_d1 = 16'hBEEF;
        @(negedge CLK); tb_c1 = C1_NOP; tb_d1 = 16'hDEAD; #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL r32_mid_valid: got %b exp 0", resp_valid); end
        @(negedge CLK); tb_d1 = 16'h0; #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL r32_resp: got valid %b err %b exp 1 0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL r32_rdata: got %h exp DEADBEEF", resp_rdata); end
        repeat (4) @(negedge CLK); #1;
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL r32_pulses: got %0d exp 1", pulses - p0); end
    endtask

    task automatic test_write32();
        send_req(C1_WRITE32, 19'h00100, 32'hCAFEF00D);
        @(negedge CLK); #1;
        checks++; if (D1 !== 16'hF00D || C1 !== C1_WRITE32) begin errors++; $display("FAIL w32_tick1: got d1 %h c1 %h exp F00D 7", D1, C1); end
        checks++; if (A1 !== 15'h0010) begin errors++; $display("FAIL w32_tick1_a1: got %h exp 0010", A1); end
        @(negedge CLK); #1;
        checks++; if (D1 !== 16'hCAFE || C1 !== C1_WRITE32) begin errors++; $display("FAIL w32_tick2: got d1 %h c1 %h exp CAFE 7", D1, C1); end
        @(negedge CLK); park(); #1;
        checks++; if ({A1, D1, C1} !== 34'h0) begin errors++; $display("FAIL w32_release: got %h/%h/%h exp released", A1, D1, C1); end
        @(negedge CLK); tb_c1 = C1_RESPONSE;
        @(negedge CLK); tb_c1 = C1_NOP; #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL w32_resp: got valid %b err %b exp 1 0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL w32_rdata_kept: got %h exp DEADBEEF", resp_rdata); end
        @(negedge CLK);
    endtask

    task automatic test_invalidate();
        send_req(C1_INVALIDATE_LINE, 19'h00012, 32'h12345678);
        tb_d1_oe = 1'b1; tb_d1 = 16'h0;
        @(negedge CLK); #1;
        checks++; if (A1 !== 15'h0001 || C1 !== 3'd4 || D1 !== 16'h0) begin errors++; $display("FAIL inv_tick1: got a1 %h c1 %h d1 %h exp 0001 4 0000", A1, C1, D1); end
        @(negedge CLK); #1;
        checks++; if (A1 !== 15'h0002 || C1 !== 3'd4 || D1 !== 16'h0) begin errors++; $display("FAIL inv_tick2: got a1 %h c1 %h d1 %h exp 0002 4 0000", A1, C1, D1); end
        @(negedge CLK); park(); tb_c1 = C1_RESPONSE; #1;
        checks++; if ({A1, D1} !== 31'h0) begin errors++; $display("FAIL inv_release: got %h/%h exp released", A1, D1); end
        @(negedge CLK); tb_c1 = C1_NOP; #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL inv_resp: got valid %b err %b exp 1 0", resp_valid, resp_err); end
        @(negedge CLK);
    endtask

    task automatic test_nop();
        send_req(C1_NOP, 19'h7FFFF, 32'hFFFFFFFF);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL nop_resp: got valid %b err %b ready %b exp 1 0 0", resp_valid, resp_err, req_ready); end
        checks++; if ({D1, C1} !== 19'h0) begin errors++; $display("FAIL nop_bus: got %h/%h exp released", D1, C1); end
        @(posedge CLK); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL nop_idle: got valid %b ready %b exp 0 1", resp_valid, req_ready); end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        send_req(C1_READ16, 19'h7FFFF, 32'h0);
        @(negedge CLK); #1;
        checks++; if (A1 !== 15'h7FFF) begin errors++; $display("FAIL b2b_tick1_a1: got %h exp 7FFF", A1); end
        @(negedge CLK);
        @(negedge CLK); park();
        req_cmd = C1_NOP; req_valid = 1'b1;
        repeat (2) @(negedge CLK);
        tb_c1 = C1_RESPONSE; tb_d1 = 16'h1357;
        @(negedge CLK); tb_c1 = C1_NOP; tb_d1 = 16'h0; #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00001357) begin errors++; $display("FAIL b2b_resp: got valid %b rdata %h exp 1 00001357", resp_valid, resp_rdata); end
        @(negedge CLK); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready %b valid %b exp 1 0", req_ready, resp_valid); end
        @(negedge CLK); #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b exp 1", resp_valid); end
        req_valid = 1'b0;
        @(negedge CLK); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_timeout();
        send_req(C1_READ8, 19'h0, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK); park(); #1;
        repeat (254) @(posedge CLK);
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL to_early: got %b exp 0", resp_valid); end
        @(posedge CLK); #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL to_resp: got valid %b err %b exp 1 1", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h00001357) begin errors++; $display("FAIL to_rdata_kept: got %h exp 00001357", resp_rdata); end
        @(posedge CLK); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL to_idle: got ready %b valid %b exp 1 0", req_ready, resp_valid); end
        @(negedge CLK);
    endtask

    task automatic test_tie();
        send_req(C1_READ8, 19'h0, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK); park(); #1;
        repeat (254) @(negedge CLK);
        tb_c1 = C1_RESPONSE; tb_d1 = 16'h0042;
        @(posedge CLK); #1;
        tb_c1 = C1_NOP; tb_d1 = 16'h0;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL tie_resp: got valid %b err %b exp 1 0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h00000042) begin errors++; $display("FAIL tie_rdata: got %h exp 00000042", resp_rdata); end
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        send_req(C1_WRITE32, 19'h7FFFF, 32'hFFFFFFFF);
        @(negedge CLK); #1;
        checks++; if (D1 !== 16'hFFFF) begin errors++; $display("FAIL rm_tick1_d1: got %h exp FFFF", D1); end
        @(posedge CLK); #2;
        RESET = 1'b1; park(); #1;
        checks++; if ({A1, D1, C1} !== 34'h0) begin errors++; $display("FAIL rm_release: got %h/%h/%h exp released", A1, D1, C1); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rm_state: got ready %b valid %b exp 1 0", req_ready, resp_valid); end
        @(negedge CLK); RESET = 1'b0;
        p0 = pulses;
        repeat (20) @(negedge CLK); #1;
        checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL rm_no_resp: got %0d pulses exp 0", pulses - p0); end
    endtask

    initial begin
        checks = 0; errors = 0; pulses = 0; p0 = 0;
        RESET = 1'b1; req_valid = 1'b0; req_cmd = C1_NOP; req_addr = '0; req_wdata = '0;
        tb_a1_oe = 1'b0; tb_d1_oe = 1'b0; tb_c1_oe = 1'b0; tb_d1 = '0; tb_c1 = '0;
        repeat (2) @(negedge CLK);
        test_reset();
        @(negedge CLK); #1;
        test_read8();
        test_read32();
        test_write32();
        test_invalidate();
        test_nop();
        test_back_to_back();
        test_timeout();
        test_tie();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_bus1_master.md
Name: cpu_bus1_master

Overview:
- CPU-side master for bus 1 (C1/A1/D1). It sits directly upstream of the cache and feeds it.
- Accepts one request at a time on a valid/ready interface and serialises it onto the shared bus as a two-tick command/address transfer.
- Releases the bus, waits for C1_RESPONSE, gathers read data (one or two ticks) and returns a single-cycle completion.
- Replaces hand-written testbench bus driving with synthesizable RTL.

Parameters:
- ADDR1_BUS_SIZE, 15, A1 width (tag+set bits).
- DATA1_BUS_SIZE, 16, D1 width.
- CTR1_BUS_SIZE, 3, C1 width.
- CACHE_TAG_SIZE, 10, tag bits of the CPU address.
- CACHE_SET_SIZE, 5, set-index bits.
- CACHE_OFFSET_SIZE, 4, byte-offset bits; full address = 19 bits.
- TIMEOUT_CYCLES, 255, maximum WAIT_RESP cycles before an error completion.

Ports:
- CLK, input, 1, clock; all logic is on the rising edge except bus release.
- RESET, input, 1, reset; asynchronous, active-high.
- req_valid, input, 1, request present.
- req_ready, output, 1, master idle and able to accept.
- req_cmd, input, CTR1_BUS_SIZE, C1 command code.
- req_addr, input, 19, {tag, set, offset}.
- req_wdata, input, 32, write data; [15:0] sent first.
- resp_valid, output, 1, one-cycle completion pulse.
- resp_err, output, 1, qualifies resp_valid; 1 = timeout.
- resp_rdata, output, 32, read data, zero-extended.
- A1, inout, ADDR1_BUS_SIZE, bus-1 address.
- D1, inout, DATA1_BUS_SIZE, bus-1 data.
- C1, inout, CTR1_BUS_SIZE, bus-1 command.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0. A1/D1/C1 are high-Z. FSM is in IDLE, timeout counter is 0.
- Reset asserted mid-operation: the bus is released immediately, without waiting for a clock edge, and the in-flight request is dropped with no completion.
- IDLE: req_ready=1. A posedge with req_valid=1 latches cmd/addr/wdata and moves to SEND1. In the same cycle req_ready falls to 0. Requests presented while busy are ignored.
- C1_NOP request: accepted, no bus activity. resp_valid=1, resp_err=0 on the next posedge, then IDLE.
- SEND1 (tick 1): drive C1=cmd and A1={tag,set}. For WRITE8/16/32 drive D1=wdata[15:0]; otherwise D1=Z.
- SEND2 (tick 2): keep C1 and D1. Drive A1=offset, zero-extended. For WRITE32 drive D1=wdata[31:16].
- On the falling edge that ends SEND2, the output-enable drops and A1/D1/C1 go to Z, so the cache owns the bus from the next posedge. Then move to WAIT_RESP.
- WAIT_RESP: sample C1 at each posedge and increment the timeout counter.
  - On C1==C1_RESPONSE, capture D1:
    - READ8: D1[7:0].
    - READ16: D1.
    - READ32: D1 into rdata[15:0], then go to RECV2.
    - Other commands: capture nothing, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES: go to DONE with resp_err=1 and resp_rdata unchanged from the previous transaction.
- RECV2: the next posedge captures D1 into rdata[31:16], then DONE. C1 is not rechecked.
- DONE: resp_valid=1 for exactly one cycle, then IDLE with req_ready=1. The earliest back-to-back acceptance is in the cycle after DONE.
- Tie at the timeout boundary: a response and the timeout arriving on the same edge count as a response (no error).
- The master never drives the bus outside SEND1/SEND2. Sampled Z/X on C1 is not a response.

Decomposition:
- Shared package (existing parameters/commands includes): bus sizes, cache address-split widths, C1 command codes (C1_NOP, C1_READ8/16/32, C1_INVALIDATE_LINE, C1_WRITE8/16/32, C1_RESPONSE), and the FSM state enum.
- Single module, no sub-module. The tristate driver is three continuous assigns gated by one oe register.

Test Plan:
- Reset, then READ8 addr=0x12345 with a bus model replying C1_RESPONSE and D1=0x00AB after 5 cycles:
  - Tick 1: A1=0x1234>>... is carried as {tag,set}=0x1234 (19-bit addr >>4 = 0x1234).
  - Tick 2: A1=0x5.
  - Result: resp_rdata=0x000000AB, resp_err=0.
- READ32 with D1 replies 0xBEEF then 0xDEAD -> resp_rdata=0xDEADBEEF, exactly one resp_valid pulse.
- WRITE32 wdata=0xCAFEF00D -> D1=0xF00D at tick 1 and 0xCAFE at tick 2; all lines are Z from the falling edge after tick 2; on response, resp_valid with resp_err=0.
- INVALIDATE_LINE addr=0x00012 (set=1, offset=2) -> C1=4 for both ticks, A1=0x001 then 0x002, D1 stays Z.
- No response from the bus model -> resp_valid with resp_err=1 exactly 255 cycles after entering WAIT_RESP; req_ready=1 the next cycle.
- RESET raised during SEND2 -> bus goes Z with no clock edge, req_ready=1, and no resp_valid is ever produced for that request.
